// File: rtl/ex_bypass_net_if.sv
// Operand-forwarding bus for ex_bypass_net: EX-stage inputs in, operands/stall/count out.
interface ex_bypass_net_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned CW   = 16
);
   logic            flush;
   logic            issue_valid;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imm;
   logic            asel;
   logic            bsel;
   logic [AW-1:0]   rd;
   logic            we;
   logic            is_load;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] rs1_in;
   logic [XLEN-1:0] rs2_in;
   logic [XLEN-1:0] rs1_br;
   logic [XLEN-1:0] rs2_br;
   logic            stall;
   logic [CW-1:0]   fwd_count;

   // Pipeline side
   modport master (
      output flush, issue_valid, rs1_addr, rs2_addr, rs1, rs2, pc, imm, asel, bsel,
             rd, we, is_load, alu_result, ld_data,
      input  rs1_in, rs2_in, rs1_br, rs2_br, stall, fwd_count
   );

   // Bypass network side
   modport slave (
      input  flush, issue_valid, rs1_addr, rs2_addr, rs1, rs2, pc, imm, asel, bsel,
             rd, we, is_load, alu_result, ld_data,
      output rs1_in, rs2_in, rs1_br, rs2_br, stall, fwd_count
   );
endinterface

// File: rtl/ex_bypass_net.sv
// EX-stage operand forwarding: tracks in-flight results downstream of EX, picks the
// youngest matching producer per source operand, flags load-use stalls and counts forwards.
module ex_bypass_net #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CW     = 16
) (
   input logic           clk,
   input logic           rst,
   ex_bypass_net_if.slave bus
);

   // Entry 0 = MEM ... entry STAGES-1 = WB
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] we_q, we_d;
   logic [STAGES-1:0] ready_q, ready_d;
   logic [AW-1:0]     rd_q   [STAGES];
   logic [AW-1:0]     rd_d   [STAGES];
   logic [XLEN-1:0]   data_q [STAGES];
   logic [XLEN-1:0]   data_d [STAGES];
   logic [CW-1:0]     count_q, count_d;

   logic            hit1, hit2, haz1, haz2;
   logic [XLEN-1:0] fwd1, fwd2;
   logic            accept;
   logic [1:0]      inc;
   logic [CW:0]     sum;

   // Per-operand lookup; scanning oldest to youngest lets the youngest match win
   always_comb begin
      hit1 = 1'b0;
      haz1 = 1'b0;
      fwd1 = bus.rs1;
      hit2 = 1'b0;
      haz2 = 1'b0;
      fwd2 = bus.rs2;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (valid_q[k] && we_q[k] && rd_q[k] == bus.rs1_addr && bus.rs1_addr != '0) begin
            hit1 = 1'b1;
            haz1 = !ready_q[k];
            fwd1 = data_q[k];
         end
         if (valid_q[k] && we_q[k] && rd_q[k] == bus.rs2_addr && bus.rs2_addr != '0) begin
            hit2 = 1'b1;
            haz2 = !ready_q[k];
            fwd2 = data_q[k];
         end
      end
      if (bus.rs1_addr == '0) fwd1 = '0;
      if (bus.rs2_addr == '0) fwd2 = '0;
   end

   assign bus.rs1_br    = fwd1;
   assign bus.rs2_br    = fwd2;
   assign bus.rs1_in    = bus.asel ? bus.pc : fwd1;
   assign bus.rs2_in    = bus.bsel ? bus.imm : fwd2;
   // Branch path needs the register value even when the ALU takes pc/imm
   assign bus.stall     = bus.issue_valid && (haz1 || haz2);
   assign bus.fwd_count = count_q;

   assign accept = bus.issue_valid && !bus.stall && !bus.flush;

   // Shift entries downstream, resolve pending load in entry 0, insert the EX instruction
   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      ready_d = ready_q;
      rd_d    = rd_q;
      data_d  = data_q;
      for (int k = STAGES - 1; k >= 1; k--) begin
         valid_d[k] = valid_q[k-1];
         we_d[k]    = we_q[k-1];
         rd_d[k]    = rd_q[k-1];
         ready_d[k] = ready_q[k-1];
         data_d[k]  = data_q[k-1];
         // Load data arrives exactly one stage after EX
         if (k == 1 && !ready_q[0]) begin
            ready_d[k] = 1'b1;
            data_d[k]  = bus.ld_data;
         end
      end
      valid_d[0] = accept;
      we_d[0]    = bus.we;
      rd_d[0]    = bus.rd;
      ready_d[0] = !bus.is_load;
      data_d[0]  = bus.alu_result;
      if (bus.flush) valid_d = '0;
   end

   // Saturating count of ALU operands taken from an entry on accepted issues
   always_comb begin
      inc     = {1'b0, hit1 && !haz1 && !bus.asel} + {1'b0, hit2 && !haz2 && !bus.bsel};
      sum     = {1'b0, count_q} + (CW + 1)'(inc);
      count_d = count_q;
      if (accept) count_d = sum[CW] ? '1 : sum[CW-1:0];
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         we_q    <= '0;
         ready_q <= '0;
         count_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            rd_q[k]   <= '0;
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_ex_bypass_net.sv
// Bench for ex_bypass_net: default (CW=16) and CW=2 instances driven in lockstep,
// expected operands/stall/count queued per cycle and compared on the falling edge.
module tb_ex_bypass_net;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ex_bypass_net_if #(.XLEN(32), .AW(5), .CW(16)) bus16 ();
   ex_bypass_net_if #(.XLEN(32), .AW(5), .CW(2))  bus2 ();

   ex_bypass_net #(.XLEN(32), .AW(5), .STAGES(2), .CW(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   ex_bypass_net #(.XLEN(32), .AW(5), .STAGES(2), .CW(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // Second instance sees the same stimulus
   assign bus2.flush       = bus16.flush;
   assign bus2.issue_valid = bus16.issue_valid;
   assign bus2.rs1_addr    = bus16.rs1_addr;
   assign bus2.rs2_addr    = bus16.rs2_addr;
   assign bus2.rs1         = bus16.rs1;
   assign bus2.rs2         = bus16.rs2;
   assign bus2.pc          = bus16.pc;
   assign bus2.imm         = bus16.imm;
   assign bus2.asel        = bus16.asel;
   assign bus2.bsel        = bus16.bsel;
   assign bus2.rd          = bus16.rd;
   assign bus2.we          = bus16.we;
   assign bus2.is_load     = bus16.is_load;
   assign bus2.alu_result  = bus16.alu_result;
   assign bus2.ld_data     = bus16.ld_data;

   typedef struct {
      int          id;
      logic [31:0] r1in;
      logic [31:0] r2in;
      logic [31:0] r1br;
      logic [31:0] r2br;
      logic        stall;
      int          cnt;
      bit          k1;
      bit          k2;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: one expectation per driven cycle, compared mid-cycle
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         if (mon_e.k1) begin
            check_val($sformatf("s%0d.d16.rs1_in", mon_e.id), bus16.rs1_in, mon_e.r1in);
            check_val($sformatf("s%0d.d16.rs1_br", mon_e.id), bus16.rs1_br, mon_e.r1br);
            check_val($sformatf("s%0d.d2.rs1_in", mon_e.id), bus2.rs1_in, mon_e.r1in);
         end
         if (mon_e.k2) begin
            check_val($sformatf("s%0d.d16.rs2_in", mon_e.id), bus16.rs2_in, mon_e.r2in);
            check_val($sformatf("s%0d.d16.rs2_br", mon_e.id), bus16.rs2_br, mon_e.r2br);
            check_val($sformatf("s%0d.d2.rs2_in", mon_e.id), bus2.rs2_in, mon_e.r2in);
         end
         check_val($sformatf("s%0d.d16.stall", mon_e.id), 32'(bus16.stall), 32'(mon_e.stall));
         check_val($sformatf("s%0d.d2.stall", mon_e.id), 32'(bus2.stall), 32'(mon_e.stall));
         check_val($sformatf("s%0d.d16.fwd_count", mon_e.id), 32'(bus16.fwd_count),
                   32'(mon_e.cnt));
         check_val($sformatf("s%0d.d2.fwd_count", mon_e.id), 32'(bus2.fwd_count),
                   32'((mon_e.cnt > 3) ? 3 : mon_e.cnt));
      end
   end

   // Drive one EX cycle; f1/f2 are the expected forwarded (branch) values,
   // add is the number of forwarded ALU operands credited at the coming edge.
   task automatic step(input int id, input bit rs, input bit fl, input bit iv,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2,
                       input bit as, input bit bs,
                       input logic [4:0] rd, input bit we, input bit ld,
                       input logic [31:0] alu, input logic [31:0] ldd,
                       input logic [31:0] f1, input logic [31:0] f2,
                       input bit est, input int add, input bit k1, input bit k2);
      exp_t e;
      @(posedge clk);
      #1;
      rst                  = rs;
      bus16.flush          = fl;
      bus16.issue_valid    = iv;
      bus16.rs1_addr       = a1;
      bus16.rs1            = d1;
      bus16.rs2_addr       = a2;
      bus16.rs2            = d2;
      bus16.asel           = as;
      bus16.bsel           = bs;
      bus16.rd             = rd;
      bus16.we             = we;
      bus16.is_load        = ld;
      bus16.alu_result     = alu;
      bus16.ld_data        = ldd;
      e.id    = id;
      e.r1br  = f1;
      e.r2br  = f2;
      e.r1in  = as ? 32'd44 : f1;
      e.r2in  = bs ? 32'd1 : f2;
      e.stall = est;
      e.cnt   = rs ? 0 : exp_cnt;
      e.k1    = k1;
      e.k2    = k2;
      sb.push_back(e);
      if (rs) exp_cnt = 0;
      else    exp_cnt += add;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus16.flush = 1'b0; bus16.issue_valid = 1'b0;
      bus16.rs1_addr = '0; bus16.rs2_addr = '0; bus16.rs1 = '0; bus16.rs2 = '0;
      bus16.pc = 32'd44; bus16.imm = 32'd1; bus16.asel = 1'b0; bus16.bsel = 1'b0;
      bus16.rd = '0; bus16.we = 1'b0; bus16.is_load = 1'b0;
      bus16.alu_result = '0; bus16.ld_data = '0;

      // id rs fl iv  a1 d1        a2 d2       as bs rd we ld alu       ldd       f1/f2 est add k1 k2
      step(0,  1, 0, 1, 1, 10,      2, 15,      0, 0, 0, 0, 0, 0,        0,       10, 15, 0, 0, 1, 1);
      step(1,  0, 0, 1, 1, 10,      2, 15,      0, 0, 0, 0, 0, 0,        0,       10, 15, 0, 0, 1, 1);
      step(2,  0, 0, 1, 1, 10,      2, 15,      1, 1, 0, 0, 0, 0,        0,       10, 15, 0, 0, 1, 1);
      // Plain ALU producer, then consumer in entry 0, entry 1, and past WB
      step(3,  0, 0, 1, 1, 10,      2, 15,      0, 0, 5, 1, 0, 111,      0,       10, 15, 0, 0, 1, 1);
      step(4,  0, 0, 1, 5, 'h55,    5, 'h55,    0, 0, 0, 0, 0, 0,        0,      111,111, 0, 2, 1, 1);
      step(5,  0, 0, 1, 5, 'h55,    5, 'h55,    0, 0, 0, 0, 0, 0,        0,      111,111, 0, 2, 1, 1);
      step(6,  0, 0, 1, 5, 'h55,    5, 'h55,    0, 0, 0, 0, 0, 0,        0,    'h55,'h55, 0, 0, 1, 1);
      // Youngest of two matching producers wins
      step(7,  0, 0, 1, 1, 10,      2, 15,      0, 0, 5, 1, 0, 111,      0,       10, 15, 0, 0, 1, 1);
      step(8,  0, 0, 1, 1, 10,      2, 15,      0, 0, 5, 1, 0, 222,      0,       10, 15, 0, 0, 1, 1);
      step(9,  0, 0, 1, 5, 'h55,    2, 15,      0, 0, 0, 0, 0, 0,        0,      222, 15, 0, 1, 1, 1);
      // Load-use: one stall cycle, then load data forwarded from entry 1
      step(10, 0, 0, 1, 1, 10,      2, 15,      0, 0, 7, 1, 1, 'hDEAD,   0,       10, 15, 0, 0, 1, 1);
      step(11, 0, 0, 1, 1, 10,      7, 'h77,    0, 0, 9, 1, 0, 'h999, 'hABCD,     10,  0, 1, 0, 1, 0);
      step(12, 0, 0, 1, 1, 10,      7, 'h77,    0, 0, 0, 0, 0, 0,        0,  10,'hABCD, 0, 1, 1, 1);
      // Stalled instruction must not have created an entry
      step(13, 0, 0, 1, 9, 'h99,    2, 15,      0, 0, 0, 0, 0, 0,        0,    'h99, 15, 0, 0, 1, 1);
      // x0 is never forwarded
      step(14, 0, 0, 1, 1, 10,      2, 15,      0, 0, 0, 1, 0, 99,       0,       10, 15, 0, 0, 1, 1);
      step(15, 0, 0, 1, 0, 'h1234,  2, 15,      0, 0, 6, 1, 0, 'h66,     0,        0, 15, 0, 0, 1, 1);
      // Async reset mid-cycle: entry for x6 and the count vanish before the next edge
      step(16, 1, 0, 1, 6, 'h60,    2, 15,      0, 0, 0, 0, 0, 0,        0,    'h60, 15, 0, 0, 1, 1);
      // Four double-forwarded issues: 16-bit count climbs, 2-bit count saturates at 3
      step(17, 0, 0, 1, 1, 10,      2, 15,      0, 0, 3, 1, 0, 'h33,     0,       10, 15, 0, 0, 1, 1);
      step(18, 0, 0, 1, 3, 'h30,    3, 'h30,    0, 0, 3, 1, 0, 'h33,     0,    'h33,'h33, 0, 2, 1, 1);
      step(19, 0, 0, 1, 3, 'h30,    3, 'h30,    0, 0, 3, 1, 0, 'h33,     0,    'h33,'h33, 0, 2, 1, 1);
      step(20, 0, 0, 1, 3, 'h30,    3, 'h30,    0, 0, 3, 1, 0, 'h33,     0,    'h33,'h33, 0, 2, 1, 1);
      step(21, 0, 0, 1, 3, 'h30,    3, 'h30,    0, 0, 3, 1, 0, 'h33,     0,    'h33,'h33, 0, 2, 1, 1);
      step(22, 0, 0, 1, 1, 10,      2, 15,      0, 0, 0, 0, 0, 0,        0,       10, 15, 0, 0, 1, 1);
      // Flush during a load-use stall clears the entries
      step(23, 0, 0, 1, 1, 10,      2, 15,      0, 0, 7, 1, 1, 'hDEAD,   0,       10, 15, 0, 0, 1, 1);
      step(24, 0, 1, 1, 7, 'h77,    2, 15,      0, 0, 9, 1, 0, 'h999,    0,        0, 15, 1, 0, 0, 1);
      step(25, 0, 0, 1, 7, 'h77,    9, 'h90,    0, 0, 0, 0, 0, 0,        0,    'h77,'h90, 0, 0, 1, 1);

      @(negedge clk);
      #1;
      check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
